// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Single-entry issue register sitting directly in front of the ALU.
//   Resolves op1/op2 source selection (PC / immediate / register) and the
//   writeback bypass at capture time. It then holds the ALU function,
//   operands and destination info until the downstream side consumes them.
//   While an instruction is stalled, writebacks to its source registers are
//   folded into the held operands, so they never go stale.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 kills the held entry and any same-cycle capture
//   in_valid / in_ready   upstream handshake (in_ready is combinational)
//   in_fun, in_rs1/2, in_rs1/2_data, in_imm, in_pc,
//   in_op1_pc, in_op2_imm, in_rd, in_wen    decoded instruction
//   wb_wen, wb_rd, wb_data                  writeback port (bypass source)
//   out_valid / out_ready downstream handshake
//   out_fun, out_op1, out_op2, out_rd, out_wen   registered ALU request
//
// Optional build macro ALU_ISSUE_PERF_EN
//   Adds perf_issued[31:0] (capture count) and perf_stall[31:0] (cycles with
//   out_valid && !out_ready). Both counters wrap, and flush does not clear them.
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int FUN_W = 4,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FUN_W-1:0] in_fun,
    input  logic [RA_W-1:0]  in_rs1,
    input  logic [RA_W-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             in_op1_pc,
    input  logic             in_op2_imm,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_wen,
    input  logic             wb_wen,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FUN_W-1:0] out_fun,
    output logic [XLEN-1:0]  out_op1,
    output logic [XLEN-1:0]  out_op2,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_wen
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);

    logic             valid_q, valid_d;
    logic [FUN_W-1:0] fun_q, fun_d;
    logic [XLEN-1:0]  op1_q, op1_d;
    logic [XLEN-1:0]  op2_q, op2_d;
    logic [RA_W-1:0]  rd_q, rd_d;
    logic             wen_q, wen_d;
    // Source addresses and select flags of the held entry, kept for refresh
    logic [RA_W-1:0]  rs1_q, rs1_d;
    logic [RA_W-1:0]  rs2_q, rs2_d;
    logic             op1_pc_q, op1_pc_d;
    logic             op2_imm_q, op2_imm_d;

    logic capture;
    logic stall;
    logic wb_hit1, wb_hit2;

    // x0 always reads zero; otherwise a same-cycle writeback wins over RF data
    function automatic logic [XLEN-1:0] bypass(
        input logic [RA_W-1:0] src,
        input logic [XLEN-1:0] rf_data,
        input logic            w_en,
        input logic [RA_W-1:0] w_rd,
        input logic [XLEN-1:0] w_data
    );
        if (src == '0)                 return '0;
        else if (w_en && w_rd == src)  return w_data;
        else                           return rf_data;
    endfunction

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign stall    = valid_q && !out_ready;

    // Refresh hits on the held entry; x0 and non-register operands never match
    assign wb_hit1 = wb_wen && (wb_rd != '0) && (wb_rd == rs1_q) && !op1_pc_q;
    assign wb_hit2 = wb_wen && (wb_rd != '0) && (wb_rd == rs2_q) && !op2_imm_q;

    always_comb begin
        valid_d   = valid_q;
        fun_d     = fun_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        op1_pc_d  = op1_pc_q;
        op2_imm_d = op2_imm_q;

        if (flush) begin
            // Only validity is dropped; data is stale but masked by out_valid
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d   = 1'b1;
            fun_d     = in_fun;
            op1_d     = in_op1_pc  ? in_pc  : bypass(in_rs1, in_rs1_data, wb_wen, wb_rd, wb_data);
            op2_d     = in_op2_imm ? in_imm : bypass(in_rs2, in_rs2_data, wb_wen, wb_rd, wb_data);
            rd_d      = in_rd;
            wen_d     = in_wen;
            rs1_d     = in_rs1;
            rs2_d     = in_rs2;
            op1_pc_d  = in_op1_pc;
            op2_imm_d = in_op2_imm;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (stall) begin
            if (wb_hit1) op1_d = wb_data;
            if (wb_hit2) op2_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            fun_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            op1_pc_q  <= 1'b0;
            op2_imm_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            fun_q     <= fun_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            op1_pc_q  <= op1_pc_d;
            op2_imm_q <= op2_imm_d;
        end
    end

    assign out_valid = valid_q;
    assign out_fun   = fun_q;
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;
    assign out_rd    = rd_q;
    assign out_wen   = wen_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (capture) perf_issued_q <= perf_issued_q + 32'd1;
            if (stall)   perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    localparam int XLEN  = 32;
    localparam int FUN_W = 4;
    localparam int RA_W  = 5;
    localparam logic [FUN_W-1:0] F_ADD = 4'd0;
    localparam logic [FUN_W-1:0] F_SUB = 4'd8;
    localparam logic [FUN_W-1:0] F_OR  = 4'd6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [FUN_W-1:0] in_fun = '0;
    logic [RA_W-1:0]  in_rs1 = '0, in_rs2 = '0;
    logic [XLEN-1:0]  in_rs1_data = '0, in_rs2_data = '0;
    logic [XLEN-1:0]  in_imm = '0, in_pc = '0;
    logic             in_op1_pc = 1'b0, in_op2_imm = 1'b0;
    logic [RA_W-1:0]  in_rd = '0;
    logic             in_wen = 1'b0;
    logic             wb_wen = 1'b0;
    logic [RA_W-1:0]  wb_rd = '0;
    logic [XLEN-1:0]  wb_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [FUN_W-1:0] out_fun;
    logic [XLEN-1:0]  out_op1, out_op2;
    logic [RA_W-1:0]  out_rd;
    logic             out_wen;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0]      perf_issued, perf_stall;
`endif

    alu_issue_stage #(.XLEN(XLEN), .FUN_W(FUN_W), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_fun(in_fun),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc),
        .in_op1_pc(in_op1_pc), .in_op2_imm(in_op2_imm),
        .in_rd(in_rd), .in_wen(in_wen),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_fun(out_fun),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_wen(out_wen)
`ifdef ALU_ISSUE_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard entry: expected ALU request plus source info for refresh
    typedef struct {
        logic [FUN_W-1:0] fun;
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        logic [RA_W-1:0]  rd;
        logic             wen;
        logic [RA_W-1:0]  rs1;
        logic [RA_W-1:0]  rs2;
        logic             op1_pc;
        logic             op2_imm;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    function automatic logic [XLEN-1:0] ref_src(input logic [RA_W-1:0] s,
                                                 input logic [XLEN-1:0] d);
        if (s == 0) return '0;
        if (wb_wen && wb_rd == s) return wb_data;
        return d;
    endfunction

    // Advances the reference model by one clock edge using the inputs now applied
    task automatic model_step();
        exp_t e;
        bit   cap;
        cap = in_valid && (exp_q.size() == 0 || out_ready) && !flush;
        if (flush) begin
            exp_q.delete();
        end else if (cap) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            e.fun = in_fun;  e.rd = in_rd;  e.wen = in_wen;
            e.rs1 = in_rs1;  e.rs2 = in_rs2;
            e.op1_pc = in_op1_pc;  e.op2_imm = in_op2_imm;
            e.op1 = in_op1_pc  ? in_pc  : ref_src(in_rs1, in_rs1_data);
            e.op2 = in_op2_imm ? in_imm : ref_src(in_rs2, in_rs2_data);
            exp_q.push_back(e);
        end else if (exp_q.size() != 0 && out_ready) begin
            void'(exp_q.pop_front());
        end else if (exp_q.size() != 0) begin
            if (wb_wen && wb_rd != 0 && wb_rd == exp_q[0].rs1 && !exp_q[0].op1_pc)
                exp_q[0].op1 = wb_data;
            if (wb_wen && wb_rd != 0 && wb_rd == exp_q[0].rs2 && !exp_q[0].op2_imm)
                exp_q[0].op2 = wb_data;
        end
    endtask

    // One clock: model evaluated at negedge, outputs sampled 1ns after posedge
    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [FUN_W-1:0] f,
                             input logic [RA_W-1:0] r1, input logic [XLEN-1:0] d1,
                             input logic [RA_W-1:0] r2, input logic [XLEN-1:0] d2,
                             input logic p1, input logic i2, input logic [XLEN-1:0] imm,
                             input logic [RA_W-1:0] rd);
        in_valid = 1'b1;  in_fun = f;
        in_rs1 = r1;  in_rs1_data = d1;  in_rs2 = r2;  in_rs2_data = d2;
        in_op1_pc = p1;  in_op2_imm = i2;  in_imm = imm;
        in_pc = 32'h0000_1000;  in_rd = rd;  in_wen = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", in_ready);
        else pass_cnt++;
        chk_cnt++;
        if ({out_fun, out_op1, out_op2, out_rd, out_wen} !== '0)
            $display("FAIL reset_data got %h/%h/%h/%h/%b exp all 0",
                     out_fun, out_op1, out_op2, out_rd, out_wen);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL idle got valid=%0b ready=%0b exp 0/1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        set_instr(F_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 1'b0, 32'd0, 5'd10);
        cycle();
        chk_cnt++;
        if (out_valid !== 1'b1 || {out_fun, out_op1, out_op2, out_rd, out_wen} !==
            {exp_q[0].fun, exp_q[0].op1, exp_q[0].op2, exp_q[0].rd, exp_q[0].wen})
            $display("FAIL b2b_add got v=%0b %h %h %h exp %h %h %h",
                     out_valid, out_fun, out_op1, out_op2, exp_q[0].fun, exp_q[0].op1, exp_q[0].op2);
        else pass_cnt++;
        chk_cnt++;
        if (out_op1 !== 32'd5 || out_op2 !== 32'd7)
            $display("FAIL b2b_add_const got %0d,%0d exp 5,7", out_op1, out_op2);
        else pass_cnt++;
        set_instr(F_SUB, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 1'b1, 32'd3, 5'd11);
        cycle();
        chk_cnt++;
        if (out_valid !== 1'b1 || out_fun !== F_SUB || out_op1 !== 32'd5 || out_op2 !== 32'd3 || out_rd !== 5'd11)
            $display("FAIL b2b_sub got v=%0b f=%h %0d,%0d rd=%0d exp 1 %h 5,3 11",
                     out_valid, out_fun, out_op1, out_op2, out_rd, F_SUB);
        else pass_cnt++;
        in_valid = 1'b0;
        cycle();
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drain got %0b exp 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        set_instr(F_ADD, 5'd3, 32'd1, 5'd9, 32'h99, 1'b0, 1'b0, 32'd0, 5'd4);
        wb_wen = 1'b1;  wb_rd = 5'd3;  wb_data = 32'hDEAD_BEEF;
        cycle();
        chk_cnt++;
        if (out_op1 !== exp_q[0].op1 || out_op1 !== 32'hDEAD_BEEF || out_op2 !== 32'h99)
            $display("FAIL bypass_rs1 got %h,%h exp deadbeef,99", out_op1, out_op2);
        else pass_cnt++;
        set_instr(F_OR, 5'd0, 32'h55, 5'd0, 32'h66, 1'b0, 1'b0, 32'd0, 5'd4);
        wb_rd = 5'd0;  wb_data = 32'h1111_2222;
        cycle();
        chk_cnt++;
        if (out_op1 !== 32'd0 || out_op2 !== 32'd0)
            $display("FAIL bypass_x0 got %h,%h exp 0,0", out_op1, out_op2);
        else pass_cnt++;
        // PC-sourced op1 ignores a matching writeback
        set_instr(F_ADD, 5'd5, 32'h5, 5'd6, 32'h6, 1'b1, 1'b0, 32'd0, 5'd4);
        wb_rd = 5'd5;
        cycle();
        chk_cnt++;
        if (out_op1 !== 32'h0000_1000 || out_op1 !== exp_q[0].op1)
            $display("FAIL bypass_pc got %h exp 00001000", out_op1);
        else pass_cnt++;
        in_valid = 1'b0;  wb_wen = 1'b0;
        cycle();
    endtask

    task automatic test_stall_refresh();
        // Register-sourced op2 refreshed by a writeback during stall
        out_ready = 1'b0;
        set_instr(F_ADD, 5'd1, 32'h11, 5'd4, 32'h44, 1'b0, 1'b0, 32'd0, 5'd7);
        cycle();
        in_valid = 1'b1;  in_rs1_data = 32'hBAD;
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %0b exp 0", in_ready);
        else pass_cnt++;
        wb_wen = 1'b1;  wb_rd = 5'd4;  wb_data = 32'h1234;
        cycle();
        chk_cnt++;
        if (out_valid !== 1'b1 || out_op2 !== 32'h1234 || out_op1 !== 32'h11 || out_op2 !== exp_q[0].op2)
            $display("FAIL stall_refresh got v=%0b %h,%h exp 1 11,1234", out_valid, out_op1, out_op2);
        else pass_cnt++;
        in_valid = 1'b0;  wb_wen = 1'b0;  out_ready = 1'b1;
        cycle();
        // Immediate-sourced op2 must not be refreshed
        out_ready = 1'b0;
        set_instr(F_SUB, 5'd1, 32'h11, 5'd4, 32'h44, 1'b0, 1'b1, 32'h77, 5'd7);
        cycle();
        in_valid = 1'b0;  wb_wen = 1'b1;  wb_rd = 5'd4;  wb_data = 32'h5678;
        cycle();
        chk_cnt++;
        if (out_op2 !== 32'h77 || out_op1 !== 32'h11)
            $display("FAIL stall_imm got %h,%h exp 11,77", out_op1, out_op2);
        else pass_cnt++;
        wb_wen = 1'b0;  out_ready = 1'b1;
        cycle();
        // rs1 == rs2 refreshes both operands
        out_ready = 1'b0;
        set_instr(F_OR, 5'd6, 32'h60, 5'd6, 32'h60, 1'b0, 1'b0, 32'd0, 5'd8);
        cycle();
        in_valid = 1'b0;  wb_wen = 1'b1;  wb_rd = 5'd6;  wb_data = 32'hCAFE;
        cycle();
        chk_cnt++;
        if (out_op1 !== 32'hCAFE || out_op2 !== 32'hCAFE || out_op1 !== exp_q[0].op1)
            $display("FAIL stall_same_rs got %h,%h exp cafe,cafe", out_op1, out_op2);
        else pass_cnt++;
        wb_wen = 1'b0;  out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_instr(F_ADD, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 1'b0, 32'd0, 5'd3);
        cycle();
        set_instr(F_SUB, 5'd1, 32'hA, 5'd2, 32'hB, 1'b0, 1'b0, 32'd0, 5'd9);
        flush = 1'b1;
        cycle();
        chk_cnt++;
        if (out_valid !== 1'b0 || exp_q.size() != 0)
            $display("FAIL flush_kill got %0b exp 0", out_valid);
        else pass_cnt++;
        flush = 1'b0;
        cycle();
        chk_cnt++;
        if (out_valid !== 1'b1 || out_fun !== F_SUB || out_op1 !== 32'hA || out_op2 !== 32'hB || out_rd !== 5'd9)
            $display("FAIL flush_recapture got v=%0b f=%h %h,%h rd=%0d exp 1 %h a,b 9",
                     out_valid, out_fun, out_op1, out_op2, out_rd, F_SUB);
        else pass_cnt++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        set_instr(F_ADD, 5'd1, 32'h31, 5'd2, 32'h32, 1'b0, 1'b0, 32'd0, 5'd5);
        cycle();
        in_valid = 1'b0;
        chk_cnt++;
        if (out_valid !== 1'b1) $display("FAIL rst_full_pre got %0b exp 1", out_valid);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0 || out_op1 !== 32'd0)
            $display("FAIL rst_async got v=%0b op1=%h exp 0/0", out_valid, out_op1);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

`ifdef ALU_ISSUE_PERF_EN
    task automatic test_perf();
        @(negedge clk);  rst_n = 1'b0;  exp_q.delete();
        @(negedge clk);  rst_n = 1'b1;
        @(posedge clk);  #1;
        out_ready = 1'b0;
        set_instr(F_ADD, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 1'b0, 32'd0, 5'd3);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        out_ready = 1'b1;
        set_instr(F_SUB, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 1'b0, 32'd0, 5'd3);
        cycle();
        cycle();
        in_valid = 1'b0;
        cycle();
        chk_cnt++;
        if (perf_issued !== 32'd3 || perf_stall !== 32'd2)
            $display("FAIL perf_counts got %0d/%0d exp 3/2", perf_issued, perf_stall);
        else pass_cnt++;
        force dut.perf_issued_q = 32'hFFFF_FFFF;
        #1 release dut.perf_issued_q;
        set_instr(F_OR, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 1'b0, 32'd0, 5'd3);
        cycle();
        in_valid = 1'b0;
        chk_cnt++;
        if (perf_issued !== 32'd0) $display("FAIL perf_wrap got %h exp 0", perf_issued);
        else pass_cnt++;
        cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_bypass();
        test_stall_refresh();
        test_flush();
        test_reset_full();
`ifdef ALU_ISSUE_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue pipeline register directly upstream of the ALU.
- Accepts decoded instructions with register-file read data; resolves operand selection and writeback bypass; registers ALU function, op1 and op2 plus destination info for the ALU and writeback path.
- Single-entry buffer with valid/ready handshake on both sides, stall hold and synchronous flush.
- Held operands are kept coherent with writebacks that land while the stage is stalled.

Parameters:
- XLEN, 32, datapath width of operands, immediate, PC and writeback data.
- FUN_W, 4, width of the ALU function code (matches ALU fun field).
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the held instruction and any same-cycle capture.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept this cycle.
- in_fun  in  FUN_W  ALU function code.
- in_rs1, in_rs2  in  RA_W each  source register addresses.
- in_rs1_data, in_rs2_data  in  XLEN each  register-file read data.
- in_imm  in  XLEN  sign-extended immediate.
- in_pc  in  XLEN  instruction PC.
- in_op1_pc  in  1  op1 = PC instead of rs1.
- in_op2_imm  in  1  op2 = immediate instead of rs2.
- in_rd  in  RA_W  destination register.
- in_wen  in  1  instruction writes rd.
- wb_wen  in  1  writeback port write enable.
- wb_rd  in  RA_W  writeback destination.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  registered instruction valid toward ALU.
- out_ready  in  1  ALU/downstream consumes this cycle.
- out_fun  out  FUN_W  registered ALU function.
- out_op1, out_op2  out  XLEN each  registered ALU operands.
- out_rd  out  RA_W  registered destination.
- out_wen  out  1  registered write enable.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0; out_fun, out_op1, out_op2, out_rd, out_wen = 0; internal held rs1/rs2 addresses and source-select flags = 0. Reset asserted mid-stall discards the held instruction.
- Stage state is EMPTY (out_valid=0) or FULL (out_valid=1).
- in_ready = !out_valid || out_ready; combinational; independent of in_valid; not gated by flush.
- Capture: fires when in_valid && in_ready && !flush. Latency is 1 cycle: capture edge to out_valid=1.
- Bypass operand value for source s:
  - s==0: value is 0 (x0), regardless of wb traffic or read data.
  - else wb_wen && wb_rd==s: value is wb_data.
  - otherwise: register-file read data.
- Captured operands:
  - op1 = in_op1_pc ? in_pc : bypass(rs1).
  - op2 = in_op2_imm ? in_imm : bypass(rs2).
- Transitions:
  - FULL and out_ready, no capture: becomes EMPTY; data registers hold last values.
  - FULL and out_ready with capture: stays FULL with the new instruction; no bubble, no extra cycle.
  - FULL and !out_ready: all out_* hold, except held-operand refresh below.
- Held-operand refresh, while FULL && !out_ready:
  - wb_wen && wb_rd!=0 && wb_rd==held rs1 && op1 not PC-sourced: out_op1 <= wb_data next edge.
  - Same rule for op2 (rs2, not immediate-sourced).
  - rs1==rs2 updates both operands.
- flush=1: next edge out_valid=0. Flush dominates capture and refresh. Data registers may hold stale values; out_valid=0 marks them invalid.
- out_wen is always qualified by out_valid downstream; out_wen is not forced to 0 on flush.
- No arithmetic in this block; all widths pass through unchanged.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- Defined:
  - Adds outputs perf_issued [31:0] and perf_stall [31:0], both reset to 0.
  - perf_issued increments on each capture edge.
  - perf_stall increments each cycle with out_valid && !out_ready.
  - Both wrap modulo 2^32. Flush does not clear them.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, all out_* = 0; assert rst_n low while FULL -> out_valid=0 immediately, without waiting for a clock edge.
- Back-to-back issue with out_ready=1:
  - Cycle 0: fun=ADD, rs1_data=5, rs2_data=7.
  - Cycle 1: fun=SUB, op2_imm=1, imm=3.
  - Expected: consecutive cycles show (5,7) then (5,3) with the matching fun; no bubbles.
- Capture bypass: in_rs1=3, in_rs1_data=1, wb_wen=1, wb_rd=3, wb_data=0xDEAD_BEEF same cycle -> out_op1=0xDEADBEEF. Repeat with rs1=0 and wb_rd=0 -> out_op1=0.
- Stall refresh:
  - Hold out_ready=0 with held rs2=4, op2 from register.
  - Writeback wb_rd=4, wb_data=0x1234 -> out_op2=0x1234 next cycle; out_op1 unchanged.
  - Same sequence with op2_imm=1 -> out_op2 unchanged.
- Flush priority: FULL, out_ready=0, in_valid=1, flush=1 -> next cycle out_valid=0 and new instruction not captured; following cycle with flush=0 captures normally.
- ALU_ISSUE_PERF_EN: 3 issues plus 2 stall cycles -> perf_issued=3, perf_stall=2; preload perf_issued=0xFFFFFFFF via force, one more issue -> 0.
